// File: rtl/loopback_nch_pkg.sv
// Shared definitions for the N-channel loopback core.
// Holds the routing mode encodings, the drain FSM encodings and the
// channel routing helpers used by the top level.
package loopback_nch_pkg;

    localparam logic MODE_STRAIGHT = 1'b0;
    localparam logic MODE_ROTATE   = 1'b1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Destination FIFO index for a byte arriving on source channel s.
    function automatic int dest(input int s, input logic mode, input int channels);
        if (mode == MODE_ROTATE && channels > 1) begin
            return (s + 1) % channels;
        end
        return s;
    endfunction

    // Inverse of dest(): source channel feeding destination FIFO d.
    function automatic int src(input int d, input logic mode, input int channels);
        if (mode == MODE_ROTATE && channels > 1) begin
            return (d + channels - 1) % channels;
        end
        return d;
    endfunction

endpackage

// File: rtl/loopback_fifo.sv
// One-channel synchronous byte FIFO with occupancy output.
// Latency: a write into an empty FIFO shows as !empty on the next cycle.
// Backpressure: writes are ignored while full, reads ignored while empty.
// Ports: clk_i/rst_i (async, active-high); wr_data/wr_en in; rd_data (head),
// rd_en in; full, empty, level (wr - rd) out. All outputs are registered state.
module loopback_fifo #(
    parameter  int DEPTH = 8,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic [7:0]    rd_data,
    input  logic          rd_en,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic          wr_fire;
    logic          rd_fire;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = LW'(wr_ptr_q - rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Full blocks the write even when a read frees a slot in the same cycle,
    // so the writer's ready never depends on the reader's handshake.
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (wr_fire) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/loopback_nch.sv
// N-channel CDC loopback: OUT streams routed straight or rotated into per-channel IN FIFOs.
// Latency: 1 cycle from rx accept to tx_valid_o when the destination FIFO was empty.
// Backpressure: rx_ready_o drops when the destination FIFO is full or while draining for a mode change.
// Ports: clk_i/rst_i (async, active-high); mode_i requested routing, mode_o routing in effect;
// rx_* per-channel byte inputs (8 bits per channel), tx_* per-channel byte outputs;
// level_o per-channel FIFO occupancy, LW bits per channel.
module loopback_nch
    import loopback_nch_pkg::*;
#(
    parameter  int CHANNELS = 7,
    parameter  int DEPTH    = 8,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mode_i,
    output logic                   mode_o,
    input  logic [8*CHANNELS-1:0]  rx_data_i,
    input  logic [CHANNELS-1:0]    rx_valid_i,
    output logic [CHANNELS-1:0]    rx_ready_o,
    output logic [8*CHANNELS-1:0]  tx_data_o,
    output logic [CHANNELS-1:0]    tx_valid_o,
    input  logic [CHANNELS-1:0]    tx_ready_i,
    output logic [LW*CHANNELS-1:0] level_o
);

    state_t state_q, state_d;
    logic   mode_q, mode_d;

    logic [CHANNELS-1:0] fifo_full;
    logic [CHANNELS-1:0] fifo_empty;
    logic [CHANNELS-1:0] fifo_wr_en;
    logic [CHANNELS-1:0] fifo_rd_en;
    logic [7:0]          fifo_wr_dat [CHANNELS];

    assign mode_o = mode_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Rotate-mode neighbours are fixed per channel, so routing is a 2:1 mux on mode_q.
        localparam int SRC_ROT = src(g, MODE_ROTATE, CHANNELS);
        localparam int DST_ROT = dest(g, MODE_ROTATE, CHANNELS);

        assign rx_ready_o[g] = (state_q == ST_RUN) &
                               ~((mode_q == MODE_ROTATE) ? fifo_full[DST_ROT] : fifo_full[g]);

        assign fifo_wr_en[g]  = (mode_q == MODE_ROTATE) ?
                                (rx_valid_i[SRC_ROT] & rx_ready_o[SRC_ROT]) :
                                (rx_valid_i[g] & rx_ready_o[g]);
        assign fifo_wr_dat[g] = (mode_q == MODE_ROTATE) ?
                                rx_data_i[8*SRC_ROT +: 8] : rx_data_i[8*g +: 8];

        assign fifo_rd_en[g]  = tx_ready_i[g] & ~fifo_empty[g];
        assign tx_valid_o[g]  = ~fifo_empty[g];

        loopback_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .wr_data (fifo_wr_dat[g]),
            .wr_en   (fifo_wr_en[g]),
            .rd_data (tx_data_o[8*g +: 8]),
            .rd_en   (fifo_rd_en[g]),
            .full    (fifo_full[g]),
            .empty   (fifo_empty[g]),
            .level   (level_o[LW*g +: LW])
        );
    end

    // A mode request stops intake; the new mode is latched only once every FIFO
    // is empty so no byte is read out on a channel chosen by the other mode.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_RUN: begin
                if (mode_i != mode_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (&fifo_empty) begin
                    state_d = ST_RUN;
                    mode_d  = mode_i;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            mode_q  <= MODE_STRAIGHT;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_loopback_nch.sv
// Bench for loopback_nch: per-cycle comparison against a queue-based model,
// a routing vector table and directed sequences for the multi-cycle cases.
module tb_loopback_nch;

    localparam int C  = 7;
    localparam int D  = 8;
    localparam int LW = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           mode_i;
    logic           mode_o;
    logic [8*C-1:0] rx_data_i;
    logic [C-1:0]   rx_valid_i;
    logic [C-1:0]   rx_ready_o;
    logic [8*C-1:0] tx_data_o;
    logic [C-1:0]   tx_valid_o;
    logic [C-1:0]   tx_ready_i;
    logic [LW*C-1:0] level_o;

    loopback_nch #(.CHANNELS(C), .DEPTH(D)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .mode_i     (mode_i),
        .mode_o     (mode_o),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .level_o    (level_o)
    );

    always #5 clk_i = ~clk_i;

    int nvec  = 0;
    int nfail = 0;

    // Reference model: one byte queue per destination, the mode in effect and a drain flag.
    logic [7:0] mq    [C][$];
    logic [7:0] txlog [C][$];
    logic       mode_m;
    logic       drain_m;
    logic [C-1:0] acc;

    typedef struct {
        logic       mode;
        int         src;
        logic [7:0] dat;
        int         exp_dst;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mdest(input int s, input logic m);
        return m ? (s + 1) % C : s;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < C; k++) mq[k].delete();
        mode_m  = 1'b0;
        drain_m = 1'b0;
    endtask

    task automatic clear_logs();
        for (int k = 0; k < C; k++) txlog[k].delete();
    endtask

    task automatic check_model();
        logic [C-1:0]    er, ev;
        logic [8*C-1:0]  ed, dm;
        logic [LW*C-1:0] el;
        er = '0; ev = '0; ed = '0; dm = '0; el = '0;
        for (int k = 0; k < C; k++) begin
            er[k] = !drain_m && (mq[mdest(k, mode_m)].size() < D);
            ev[k] = (mq[k].size() != 0);
            if (ev[k]) begin
                ed[8*k +: 8] = mq[k][0];
                dm[8*k +: 8] = 8'hFF;
            end
            el[LW*k +: LW] = LW'(mq[k].size());
        end
        check("model rx_ready", rx_ready_o, er);
        check("model tx_valid", tx_valid_o, ev);
        check("model tx_data", tx_data_o & dm, ed);
        check("model level", level_o, el);
        check("model mode", mode_o, mode_m);
    endtask

    task automatic model_step();
        logic [C-1:0] rdy;
        bit all_empty;
        if (rst_i) begin
            clear_model();
            return;
        end
        all_empty = 1'b1;
        for (int k = 0; k < C; k++) begin
            rdy[k] = !drain_m && (mq[mdest(k, mode_m)].size() < D);
            if (mq[k].size() != 0) all_empty = 1'b0;
        end
        for (int k = 0; k < C; k++)
            if (tx_ready_i[k] && mq[k].size() != 0) void'(mq[k].pop_front());
        for (int k = 0; k < C; k++)
            if (rx_valid_i[k] && rdy[k]) mq[mdest(k, mode_m)].push_back(rx_data_i[8*k +: 8]);
        if (!drain_m) begin
            if (mode_i != mode_m) drain_m = 1'b1;
        end else if (all_empty) begin
            drain_m = 1'b0;
            mode_m  = mode_i;
        end
    endtask

    // Inputs change 1 time unit after posedge; outputs are checked at negedge.
    task automatic cycle();
        @(negedge clk_i);
        check_model();
        acc = rx_valid_i & rx_ready_o;
        for (int k = 0; k < C; k++)
            if (tx_valid_o[k] && tx_ready_i[k]) txlog[k].push_back(tx_data_o[8*k +: 8]);
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic set_mode(input logic m);
        mode_i = m;
        for (int i = 0; i < 20 && mode_o != m; i++) cycle();
        check("mode settle", mode_o, m);
    endtask

    initial begin
        int n;
        int cnt [3];
        int tgt [3];
        int srcs [3];
        logic [C-1:0] one;
        one = 1;

        tbl[0] = '{mode: 1'b1, src: 6, dat: 8'hA1, exp_dst: 0};
        tbl[1] = '{mode: 1'b1, src: 0, dat: 8'h5A, exp_dst: 1};
        tbl[2] = '{mode: 1'b1, src: 3, dat: 8'h3C, exp_dst: 4};
        tbl[3] = '{mode: 1'b0, src: 3, dat: 8'hC3, exp_dst: 3};
        tbl[4] = '{mode: 1'b0, src: 6, dat: 8'h66, exp_dst: 6};
        tbl[5] = '{mode: 1'b0, src: 0, dat: 8'hF0, exp_dst: 0};

        // ---- reset state ----
        rst_i = 1'b0; mode_i = 1'b0; rx_valid_i = '0; rx_data_i = '0; tx_ready_i = '1;
        clear_model();
        clear_logs();
        #2 rst_i = 1'b1;
        #1;
        check("reset tx_valid", tx_valid_o, '0);
        check("reset tx_data", tx_data_o, '0);
        check("reset level", level_o, '0);
        check("reset mode", mode_o, 1'b0);
        check("reset rx_ready", rx_ready_o, {C{1'b1}});
        @(posedge clk_i); #1;
        cycle();
        rst_i = 1'b0;
        cycle();

        // ---- straight mode streaming on ch0 and ch6 ----
        clear_logs();
        for (int i = 0; i < 7; i++) begin
            rx_valid_i = 7'b1000001;
            rx_data_i[7:0]   = 8'h01 + 8'(i);
            rx_data_i[55:48] = 8'hD1 + 8'(i);
            cycle();
            if (i == 0) begin
                check("first tx_valid ch0", tx_valid_o[0], 1'b1);
                check("first tx_data ch0", tx_data_o[7:0], 8'h01);
            end
        end
        rx_valid_i = '0;
        for (int i = 0; i < 3; i++) cycle();
        check("straight ch0 count", txlog[0].size(), 7);
        check("straight ch6 count", txlog[6].size(), 7);
        for (int i = 0; i < 7 && i < txlog[0].size() && i < txlog[6].size(); i++) begin
            check("straight ch0 byte", txlog[0][i], 8'h01 + 8'(i));
            check("straight ch6 byte", txlog[6][i], 8'hD1 + 8'(i));
        end

        // ---- full boundary on ch1 ----
        clear_logs();
        tx_ready_i[1] = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            rx_valid_i[1] = (n < 10);
            rx_data_i[15:8] = 8'h81 + 8'(n);
            cycle();
            if (acc[1]) n++;
        end
        check("full accepted", n, 8);
        check("full rx_ready ch1", rx_ready_o[1], 1'b0);
        check("full level ch1", level_o[2*LW-1:LW], 4'd8);
        tx_ready_i[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_valid_i[1] = (n < 10);
            rx_data_i[15:8] = 8'h81 + 8'(n);
            cycle();
            if (acc[1]) n++;
        end
        rx_valid_i = '0;
        check("full total accepted", n, 10);
        check("full emitted count", txlog[1].size(), 10);
        for (int i = 0; i < 10 && i < txlog[1].size(); i++)
            check("full emitted byte", txlog[1][i], 8'h81 + 8'(i));

        // ---- idle mode change: one-cycle rx_ready dropout ----
        tx_ready_i = '1;
        cycle();
        mode_i = 1'b1;
        cycle();
        check("idle drain rx_ready", rx_ready_o, '0);
        check("idle drain mode", mode_o, 1'b0);
        cycle();
        check("idle run rx_ready", rx_ready_o, {C{1'b1}});
        check("idle run mode", mode_o, 1'b1);

        // ---- routing table ----
        for (int v = 0; v < 6; v++) begin
            set_mode(tbl[v].mode);
            rx_valid_i = one << tbl[v].src;
            rx_data_i[8*tbl[v].src +: 8] = tbl[v].dat;
            cycle();
            rx_valid_i = '0;
            check("route tx_valid", tx_valid_o, one << tbl[v].exp_dst);
            check("route tx_data", tx_data_o[8*tbl[v].exp_dst +: 8], tbl[v].dat);
            cycle();
        end

        // ---- mode change with bytes pending on ch2 ----
        clear_logs();
        tx_ready_i[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_valid_i[2] = 1'b1;
            rx_data_i[23:16] = 8'h21 + 8'(i);
            cycle();
        end
        rx_valid_i = '0;
        mode_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("pending rx_ready", rx_ready_o, '0);
            check("pending mode", mode_o, 1'b0);
        end
        tx_ready_i[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("draining mode", mode_o, 1'b0);
            check("draining rx_ready", rx_ready_o, '0);
        end
        cycle();
        check("drained mode", mode_o, 1'b1);
        check("drained rx_ready", rx_ready_o, {C{1'b1}});
        check("drained ch2 count", txlog[2].size(), 3);

        // ---- asynchronous reset mid-operation (rotate mode, levels 5/3/8) ----
        tx_ready_i = 7'b1111000;
        srcs = '{6, 0, 1};
        tgt  = '{5, 3, 8};
        cnt  = '{0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 3; k++) begin
                rx_valid_i[srcs[k]] = (cnt[k] < tgt[k]);
                rx_data_i[8*srcs[k] +: 8] = 8'h10 * 8'(k + 1) + 8'(cnt[k]);
            end
            cycle();
            for (int k = 0; k < 3; k++) if (acc[srcs[k]]) cnt[k]++;
        end
        rx_valid_i = '0;
        check("pre-reset levels", level_o[3*LW-1:0], {4'd8, 4'd3, 4'd5});
        #2 rst_i = 1'b1; mode_i = 1'b0;
        #1;
        clear_model();
        check("mid reset tx_valid", tx_valid_o, '0);
        check("mid reset level", level_o, '0);
        check("mid reset mode", mode_o, 1'b0);
        check("mid reset rx_ready", rx_ready_o, {C{1'b1}});
        check("mid reset tx_data", tx_data_o, '0);
        @(posedge clk_i); #1;
        cycle();
        rst_i = 1'b0;
        tx_ready_i = '1;
        clear_logs();
        for (int i = 0; i < 5; i++) cycle();
        n = 0;
        for (int k = 0; k < C; k++) n += txlog[k].size();
        check("no stale bytes", n, 0);

        // ---- random traffic ----
        for (int i = 0; i < 1500; i++) begin
            rx_valid_i = C'($urandom);
            rx_data_i  = (8*C)'({$urandom, $urandom});
            tx_ready_i = C'($urandom | $urandom);
            if ($urandom_range(0, 59) == 0) mode_i = ~mode_i;
            cycle();
        end
        rx_valid_i = '0;
        tx_ready_i = '1;
        for (int i = 0; i < 30; i++) cycle();
        check("final tx_valid", tx_valid_o, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
